// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register address width and the hard-wired zero register.
package hazard_controller_pkg;

    localparam int REG_ADDR_W = 5;

    // Register x0 reads as zero, so a load targeting it never creates a hazard.
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Signal bundle between the decode/execute datapath and the hazard controller.
// The controller uses the slave view; the datapath uses the master view.
interface hazard_controller_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_busy;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_busy,
        input  pc_write, ifid_write, idex_write, idex_bubble, ifid_flush,
               stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_busy,
        output pc_write, ifid_write, idex_write, idex_bubble, ifid_flush,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_controller_hazard_compare.sv
// Load-use hazard detector: the load in EX writes a register that the
// instruction in ID is about to read.
module hazard_compare
    import hazard_controller_pkg::*;
#(
    parameter int W = REG_ADDR_W
) (
    input  logic [W-1:0] id_rs1,
    input  logic [W-1:0] id_rs2,
    input  logic         id_uses_rs2,
    input  logic [W-1:0] ex_rd,
    input  logic         ex_mem_read,
    output logic         load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // Compare the load destination against each source that is actually read.
    always_comb begin
        rs1_hit  = (ex_rd == id_rs1);
        rs2_hit  = id_uses_rs2 && (ex_rd == id_rs2);
        load_use = ex_mem_read && (ex_rd != W'(X0)) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle branch
// flushes, whole-pipe freeze on memory busy, saturating perf counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32,
    parameter int REG_W        = 5
) (
    input logic                clk,
    input logic                reset,
    hazard_controller_if.slave bus
);

    // Wide enough to hold FLUSH_CYCLES-1 even when FLUSH_CYCLES is 1.
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    state_t           state;
    logic [FC_W-1:0]  flush_cnt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic load_use;
    logic busy;
    logic branch;
    logic flushing;
    logic stall;

    hazard_compare #(.W(REG_W)) u_compare (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs2 (bus.id_uses_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .load_use    (load_use)
    );

    // Resolve this cycle's event by priority: busy > branch > flush > load-use.
    // Reset masks every event so the pipe free-runs during the reset cycle.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        busy     = !reset && bus.mem_busy;
        branch   = !reset && !busy && bus.ex_branch_taken;
        flushing = !reset && !busy && !branch && (state == FLUSH);
        stall    = !reset && !busy && !branch && (state == RUN) && load_use;
    end

    // Zero-latency control outputs derived from the resolved event.
    always_comb begin
        bus.pc_write     = !busy && !stall;
        bus.ifid_write   = !busy && !stall;
        bus.idex_write   = !busy;
        bus.idex_bubble  = branch || flushing || stall;
        bus.ifid_flush   = branch || flushing;
        bus.stall_cycles = stall_q;
        bus.flush_events = flush_q;
    end

    // FSM, flush countdown and saturating counters; everything holds while busy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else if (branch) begin
            if (flush_q != '1) flush_q <= flush_q + 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state     <= FLUSH;
                flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            end else begin
                state     <= RUN;
                flush_cnt <= '0;
            end
        end else if (flushing) begin
            flush_cnt <= flush_cnt - 1'b1;
            if (flush_cnt <= FC_W'(1)) state <= RUN;
        end else if (stall) begin
            if (stall_q != '1) stall_q <= stall_q + 1'b1;
        end
    end

endmodule
